mult_accum_pipe: RTL and testbench

Parametrised, pipelined, multi-channel signed multiply-accumulate engine. It is the next generation of the single-lane DSP accumulator. It accepts a stream of (channel, a, b) beats with valid/ready flow control and multiplies in a registered stage. It accumulates into a per-channel accumulator bank with add/subtract/load modes, and emits a rounded, width-reduced result per channel when a beat marked last retires. It sits between the sample datapath (filter/effects taps) and downstream consumers that need one result per channel per frame.

---
 rtl/mult_accum_pipe.sv | 152 +++++++++++++++
 tb/tb_mult_accum_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_accum_pipe.sv
// Pipelined multi-channel signed multiply-accumulate with per-channel banks and a rounded, width-reduced result per run.
// Optional MULT_ACCUM_SAT_EN: saturating accumulate/reduction with an overflow flag (default build wraps and truncates).
module mult_accum_pipe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int NCH    = 4,
  parameter int SHIFT  = 15,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_sub,
  input  logic              in_load,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  // Handshake: a beat moves on a rising edge when valid && ready. A pending
  // unconsumed result freezes every stage, so in_ready depends on the output side only.
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RSH) : '0;
`ifdef MULT_ACCUM_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] D_MAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] D_MIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W:0] sum_w;
`endif

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic                     s1_valid, s1_sub, s1_load, s1_last;
  logic [CH_W-1:0]          s1_ch;
  logic signed [DATA_W-1:0] s1_a, s1_b;
  logic                     s2_valid, s2_sub, s2_load, s2_last;
  logic [CH_W-1:0]          s2_ch;
  logic signed [2*DATA_W-1:0] s2_p;
  logic                     s3_valid, s3_sub, s3_load, s3_last;
  logic [CH_W-1:0]          s3_ch;
  logic signed [ACC_W-1:0]  s3_p;

  logic signed [ACC_W-1:0]  bank [NCH];
  logic                     ovf_bank [NCH];

  logic                     ch_ok, acc_ovf, red_ovf, res_ovf, emit;
  logic signed [ACC_W-1:0]  base, acc_next;
  logic signed [ACC_W:0]    rnd_sum, r;
  logic [DATA_W-1:0]        data_red;
  logic                     unused_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_sub <= 1'b0; s1_load <= 1'b0; s1_last <= 1'b0;
      s1_ch <= '0; s1_a <= '0; s1_b <= '0;
      s2_valid <= 1'b0; s2_sub <= 1'b0; s2_load <= 1'b0; s2_last <= 1'b0;
      s2_ch <= '0; s2_p <= '0;
      s3_valid <= 1'b0; s3_sub <= 1'b0; s3_load <= 1'b0; s3_last <= 1'b0;
      s3_ch <= '0; s3_p <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid && in_ready;
      s1_sub <= in_sub; s1_load <= in_load; s1_last <= in_last;
      s1_ch <= in_ch; s1_a <= in_a; s1_b <= in_b;
      s2_valid <= s1_valid;
      s2_sub <= s1_sub; s2_load <= s1_load; s2_last <= s1_last;
      s2_ch <= s1_ch; s2_p <= s1_a * s1_b;
      // Registered, sign-extended product feeds the single bank read-modify-write stage
      s3_valid <= s2_valid;
      s3_sub <= s2_sub; s3_load <= s2_load; s3_last <= s2_last;
      s3_ch <= s2_ch; s3_p <= ACC_W'(s2_p);
    end
  end

  always_comb begin
    ch_ok = int'(s3_ch) < NCH;
    base  = s3_load ? '0 : bank[s3_ch];
`ifdef MULT_ACCUM_SAT_EN
    sum_w = s3_sub ? ({base[ACC_W-1], base} - {s3_p[ACC_W-1], s3_p})
                   : ({base[ACC_W-1], base} + {s3_p[ACC_W-1], s3_p});
    acc_ovf  = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    acc_next = acc_ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];
`else
    acc_ovf  = 1'b0;
    acc_next = s3_sub ? (base - s3_p) : (base + s3_p);
`endif
    // One extra bit keeps the rounding add from wrapping before the shift
    rnd_sum  = {acc_next[ACC_W-1], acc_next} + RND;
    r        = rnd_sum >>> SHIFT;
    data_red = r[DATA_W-1:0];
    red_ovf  = 1'b0;
`ifdef MULT_ACCUM_SAT_EN
    if (r > D_MAX) begin
      data_red = D_MAX[DATA_W-1:0];
      red_ovf  = 1'b1;
    end else if (r < D_MIN) begin
      data_red = D_MIN[DATA_W-1:0];
      red_ovf  = 1'b1;
    end
`endif
    res_ovf = ovf_bank[s3_ch] | acc_ovf | red_ovf;
    emit    = s3_valid && s3_last && ch_ok;
  end

  assign unused_bits = ^r[ACC_W:DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        bank[i]     <= '0;
        ovf_bank[i] <= 1'b0;
      end
    end else if (!stall && s3_valid && ch_ok) begin
      if (s3_last) begin
        bank[s3_ch]     <= '0;
        ovf_bank[s3_ch] <= 1'b0;
      end else begin
        bank[s3_ch]     <= acc_next;
        ovf_bank[s3_ch] <= ovf_bank[s3_ch] | acc_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      out_valid <= emit;
      if (emit) begin
        out_ch   <= s3_ch;
        out_data <= data_red;
        out_acc  <= acc_next;
        out_ovf  <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mult_accum_pipe.sv
// Directed bench for mult_accum_pipe: scoreboard queue filled by the stimulus, drained by an output monitor.
module tb_mult_accum_pipe;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int NCH    = 4;
  localparam int SHIFT  = 15;
  localparam int CH_W   = 2;
  localparam int PW     = CH_W + DATA_W + ACC_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid, in_ready, in_sub, in_load, in_last;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_a, in_b;
  logic              out_valid, out_ready, out_ovf;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic [ACC_W-1:0]  out_acc;

  // Second instance with NCH=3 sees channel 3 as out of range
  logic              in_ready3, out_valid3, out_ovf3;
  logic [CH_W-1:0]   out_ch3;
  logic [DATA_W-1:0] out_data3;
  logic [ACC_W-1:0]  out_acc3;

  int checks = 0;
  int errors = 0;
  int u3_bad = 0;
  int u3_seen = 0;
  logic [PW-1:0] exp_q[$];

  mult_accum_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NCH(NCH), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_load(in_load), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .out_acc(out_acc), .out_ovf(out_ovf)
  );

  mult_accum_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NCH(3), .SHIFT(SHIFT)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_ch(in_ch),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_load(in_load), .in_last(in_last),
    .out_valid(out_valid3), .out_ready(1'b1), .out_ch(out_ch3), .out_data(out_data3),
    .out_acc(out_acc3), .out_ovf(out_ovf3)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [DATA_W-1:0] data,
                      input logic [ACC_W-1:0] acc, input logic ovf);
    logic [CH_W-1:0] c;
    c = CH_W'(ch);
    exp_q.push_back({c, data, acc, ovf});
  endtask

  task automatic send(input int ch, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic sub, input logic load, input logic last);
    int n;
    in_ch = CH_W'(ch); in_a = a; in_b = b;
    in_sub = sub; in_load = load; in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for ch %0d", ch);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // scoreboard monitor
  logic [PW-1:0] cur, prev;
  logic prev_stall = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cur = {out_ch, out_data, out_acc, out_ovf};
      if (out_valid && !out_ready) begin
        if (prev_stall) check1("stable_under_stall", cur, prev);
        prev = cur;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got ch %0d data %0h acc %0h, queue empty", out_ch, out_data, out_acc);
        end else begin
          check1("result", cur, exp_q.pop_front());
        end
      end
      if (out_valid3) begin
        u3_seen++;
        if (out_ch3 == 2'd3) u3_bad++;
      end
    end
  end

  // stimulus
  initial begin
    int n;
    in_valid = 1'b0; in_ch = '0; in_a = '0; in_b = '0;
    in_sub = 1'b0; in_load = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check1("rst_out_valid", out_valid, 0);
    check1("rst_out_ch", out_ch, 0);
    check1("rst_out_data", out_data, 0);
    check1("rst_out_acc", out_acc, 0);
    check1("rst_out_ovf", out_ovf, 0);
    check1("rst_in_ready", in_ready, 1);

    // single term and latency
    push(0, 16'h2000, 40'h10000000, 1'b0);
    send(0, 16'h4000, 16'h4000, 0, 0, 1);
    tick();
    tick();
    check1("latency_early", out_valid, 0);
    tick();
    check1("latency_k3", out_valid, 1);
    repeat (4) tick();

    // interleaved channels, add and subtract
    push(0, 16'h4000, 40'h0020000000, 1'b0);
    push(1, 16'hC000, 40'hFFE0000000, 1'b0);
    send(0, 16'h4000, 16'h4000, 0, 0, 0);
    send(1, 16'h4000, 16'h4000, 1, 0, 0);
    send(0, 16'h4000, 16'h4000, 0, 0, 1);
    send(1, 16'h4000, 16'h4000, 1, 0, 1);
    repeat (6) tick();

    // large products: saturating vs wrapping reduction
`ifdef MULT_ACCUM_SAT_EN
    push(2, 16'h7FFF, 40'h00BFFD0003, 1'b1);
`else
    push(2, 16'h7FFA, 40'h00BFFD0003, 1'b0);
`endif
    for (int i = 0; i < 3; i++) send(2, 16'h7FFF, 16'h7FFF, 0, 0, (i == 2));
    repeat (6) tick();

    // backpressure: four results queue up behind a stalled output
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    push(0, 16'h0001, 40'h0000008000, 1'b0);
    push(1, 16'h0002, 40'h0000010000, 1'b0);
    push(2, 16'h0003, 40'h0000018000, 1'b0);
    push(3, 16'h0004, 40'h0000020000, 1'b0);
    fork
      begin
        for (int i = 0; i < 4; i++) send(i, DATA_W'((i + 1) * 256), 16'h0080, 0, 0, 1);
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          tick();
          n++;
        end
        check1("bp_first_valid", out_valid, 1);
        check1("bp_in_ready_low", in_ready, 0);
        repeat (5) tick();
        check1("bp_in_ready_held", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
      end
    join
    repeat (8) tick();
    check1("bp_drained", exp_q.size(), 0);

    // load discards history; load+sub gives -p
    for (int i = 0; i < 5; i++) send(3, 16'd10, 16'd10, 0, 0, 0);
    push(3, 16'h0000, 40'h0000000006, 1'b0);
    send(3, 16'd2, 16'd3, 0, 1, 1);
    push(0, 16'h0000, 40'hFFFFFFFFFA, 1'b0);
    send(0, 16'd7, 16'd7, 0, 0, 0);
    send(0, 16'd2, 16'd3, 1, 1, 1);
    repeat (6) tick();

    // reset mid-run discards in-flight beats and partial sums
    send(1, 16'd5, 16'd5, 0, 0, 0);
    send(1, 16'd5, 16'd5, 0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check1("midrst_out_valid", out_valid, 0);
    check1("midrst_out_acc", out_acc, 0);
    check1("midrst_out_data", out_data, 0);
    rst = 1'b0;
    repeat (5) tick();
    check1("midrst_no_output", out_valid, 0);
    push(1, 16'h0000, 40'h0000000001, 1'b0);
    send(1, 16'd1, 16'd1, 0, 0, 1);
    repeat (6) tick();

    // final report
    check1("queue_empty", exp_q.size(), 0);
    check1("oor_ch_no_output", u3_bad, 0);
    check1("oor_dut_active", (u3_seen != 0), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
